// File: rtl/alu_iter_mdu_pkg.sv
// Shared opcodes, flag indices and mul/div FSM states for the execute-stage ALU.
package alu_iter_mdu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_NOR   = 4'h5,
    OP_SLT   = 4'h6,
    OP_SLTU  = 4'h7,
    OP_SLL   = 4'h8,
    OP_SRL   = 4'h9,
    OP_SRA   = 4'hA,
    OP_PASSB = 4'hB,
    OP_MULT  = 4'hC,
    OP_MULTU = 4'hD,
    OP_DIV   = 4'hE,
    OP_DIVU  = 4'hF
  } alu_op_e;

  localparam int unsigned FLAG_W    = 4;
  localparam int unsigned FLAG_ZERO = 0;
  localparam int unsigned FLAG_OVF  = 1;
  localparam int unsigned FLAG_NEG  = 2;
  localparam int unsigned FLAG_DVZ  = 3;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  // Codes C..F go to the iterative unit.
  function automatic logic is_muldiv(input logic [3:0] op);
    return op[3] & op[2];
  endfunction

endpackage

// File: rtl/alu_iter_mdu_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider on pre-abs'd operands,
// one bit per cycle, with sign correction applied while in the FIX state.
module alu_muldiv_iter
  import alu_iter_mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             div_i,
  input  logic             neg_lo_i,
  input  logic             neg_hi_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_c_o,
  output logic [WIDTH-1:0] hi_c_o,
  output logic [WIDTH-1:0] lo_c_o
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  md_state_e        state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic             div_q, neg_lo_q, neg_hi_q;

  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             div_ge;
  logic [PW-1:0]    prod_neg;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_ge    = (div_shift >= {1'b0, b_q});
  end

  // Sign correction: full 2W negate for products, separate negates for quotient/remainder.
  always_comb begin
    prod_neg = ~{hi_q, lo_q} + PW'(1);
    hi_c_o   = hi_q;
    lo_c_o   = lo_q;
    if (div_q) begin
      if (neg_hi_q) hi_c_o = ~hi_q + WIDTH'(1);
      if (neg_lo_q) lo_c_o = ~lo_q + WIDTH'(1);
    end else if (neg_lo_q) begin
      {hi_c_o, lo_c_o} = prod_neg;
    end
    done_c_o = (state_q == MD_FIX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MD_IDLE;
      count_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else begin
      unique case (state_q)
        MD_IDLE: begin
          if (start_i) begin
            state_q  <= MD_BUSY;
            count_q  <= '0;
            hi_q     <= '0;
            lo_q     <= a_i;
            b_q      <= b_i;
            div_q    <= div_i;
            neg_lo_q <= neg_lo_i;
            neg_hi_q <= neg_hi_i;
          end
        end
        MD_BUSY: begin
          if (div_q) begin
            hi_q <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            lo_q <= {lo_q[WIDTH-2:0], div_ge};
          end else begin
            hi_q <= mul_sum[WIDTH:1];
            lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
          end
          count_q <= count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) state_q <= MD_FIX;
        end
        MD_FIX:  state_q <= MD_IDLE;
        default: state_q <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_iter_mdu.sv
// Execute-stage ALU: one-cycle integer ops, iterative mul/div into HI/LO,
// and a registered flag word with optionally sticky OVF/DVZ.
module alu_iter_mdu
  import alu_iter_mdu_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter bit          STICKY_OV = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               op,
  input  logic [WIDTH-1:0]         x,
  input  logic [WIDTH-1:0]         y,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic                     flag_clr,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         result,
  output logic [WIDTH-1:0]         hi,
  output logic [WIDTH-1:0]         lo,
  output logic [FLAG_W-1:0]        flags
);

  localparam int unsigned SW  = $clog2(WIDTH);
  localparam int unsigned MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  alu_op_e          op_q;
  logic [WIDTH-1:0] x_q, y_q;
  logic [SW-1:0]    shamt_q;
  logic             alu_vld_q, in_ready_q, out_valid_q;
  logic [WIDTH-1:0] result_q, hi_q, lo_q;
  logic [FLAG_W-1:0] flags_q;

  logic             accept_c, md_start_c, md_signed_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c;
  logic             md_done_c;
  logic [WIDTH-1:0] md_hi_raw_c, md_lo_raw_c, md_hi_c, md_lo_c;
  logic             md_dvz_c, md_ovf_c;
  logic [WIDTH-1:0] add_c, sub_c, alu_res_c, res_c;
  logic             alu_ovf_c, res_vld_c, set_ovf_c, set_dvz_c;
  logic             ovf_keep_c, dvz_keep_c, ovf_d, dvz_d;

  assign accept_c   = in_valid & in_ready_q;
  assign md_start_c = accept_c & is_muldiv(op);

  // Operand magnitudes and result signs for the iterative unit.
  always_comb begin
    md_signed_c = ~op[0];
    a_mag_c = (md_signed_c & x[MSB]) ? ~x + WIDTH'(1) : x;
    b_mag_c = (md_signed_c & y[MSB]) ? ~y + WIDTH'(1) : y;
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .start_i  (md_start_c),
    .div_i    (op[1]),
    .neg_lo_i (md_signed_c & (x[MSB] ^ y[MSB])),
    .neg_hi_i (op[1] ? (md_signed_c & x[MSB]) : (md_signed_c & (x[MSB] ^ y[MSB]))),
    .a_i      (a_mag_c),
    .b_i      (b_mag_c),
    .done_c_o (md_done_c),
    .hi_c_o   (md_hi_raw_c),
    .lo_c_o   (md_lo_raw_c)
  );

  // Divide special cases override the iterative result.
  always_comb begin
    md_dvz_c = op_q[1] & (y_q == '0);
    md_ovf_c = (op_q == OP_DIV) & (x_q == MIN_INT) & (y_q == '1);
    md_hi_c  = md_hi_raw_c;
    md_lo_c  = md_lo_raw_c;
    if (md_dvz_c) begin
      md_hi_c = x_q;
      md_lo_c = '1;
    end else if (md_ovf_c) begin
      md_hi_c = '0;
      md_lo_c = MIN_INT;
    end
  end

  always_comb begin
    add_c     = x_q + y_q;
    sub_c     = x_q - y_q;
    alu_res_c = '0;
    alu_ovf_c = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        alu_res_c = add_c;
        alu_ovf_c = (x_q[MSB] == y_q[MSB]) & (add_c[MSB] != x_q[MSB]);
      end
      OP_SUB: begin
        alu_res_c = sub_c;
        alu_ovf_c = (x_q[MSB] != y_q[MSB]) & (sub_c[MSB] != x_q[MSB]);
      end
      OP_AND:   alu_res_c = x_q & y_q;
      OP_OR:    alu_res_c = x_q | y_q;
      OP_XOR:   alu_res_c = x_q ^ y_q;
      OP_NOR:   alu_res_c = ~(x_q | y_q);
      OP_SLT:   alu_res_c = WIDTH'($signed(x_q) < $signed(y_q));
      OP_SLTU:  alu_res_c = WIDTH'(x_q < y_q);
      OP_SLL:   alu_res_c = x_q << shamt_q;
      OP_SRL:   alu_res_c = x_q >> shamt_q;
      OP_SRA:   alu_res_c = $signed(x_q) >>> shamt_q;
      OP_PASSB: alu_res_c = y_q;
      default:  alu_res_c = '0;
    endcase
  end

  // Flag next-state: a setting result beats a coincident flag_clr.
  always_comb begin
    res_vld_c  = alu_vld_q | md_done_c;
    res_c      = alu_vld_q ? alu_res_c : md_lo_c;
    set_ovf_c  = alu_vld_q ? alu_ovf_c : (md_done_c & md_ovf_c);
    set_dvz_c  = ~alu_vld_q & md_done_c & md_dvz_c;
    ovf_keep_c = flags_q[FLAG_OVF] & ~flag_clr;
    dvz_keep_c = flags_q[FLAG_DVZ] & ~flag_clr;
    ovf_d      = ovf_keep_c;
    dvz_d      = dvz_keep_c;
    if (res_vld_c) begin
      ovf_d = set_ovf_c | (STICKY_OV & ovf_keep_c);
      dvz_d = set_dvz_c | (STICKY_OV & dvz_keep_c);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= OP_ADD;
      x_q         <= '0;
      y_q         <= '0;
      shamt_q     <= '0;
      alu_vld_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      flags_q     <= '0;
    end else begin
      if (accept_c) begin
        op_q    <= alu_op_e'(op);
        x_q     <= x;
        y_q     <= y;
        shamt_q <= shamt;
      end
      alu_vld_q <= accept_c & ~is_muldiv(op);
      if (md_start_c)     in_ready_q <= 1'b0;
      else if (md_done_c) in_ready_q <= 1'b1;
      out_valid_q <= res_vld_c;
      if (res_vld_c) begin
        result_q           <= res_c;
        flags_q[FLAG_ZERO] <= (res_c == '0);
        flags_q[FLAG_NEG]  <= res_c[MSB];
      end
      if (md_done_c) begin
        hi_q <= md_hi_c;
        lo_q <= md_lo_c;
      end
      flags_q[FLAG_OVF] <= ovf_d;
      flags_q[FLAG_DVZ] <= dvz_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_iter_mdu.sv
// Directed self-checking bench for alu_iter_mdu at WIDTH=32, STICKY_OV=1.
module tb_alu_iter_mdu;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flag_clr, out_valid;
  logic [3:0]  op;
  logic [31:0] x, y, result, hi, lo;
  logic [4:0]  shamt;
  logic [3:0]  flags;

  int n_cmp = 0;
  int n_bad = 0;
  int busy, pulses;

  alu_iter_mdu #(.WIDTH(32), .STICKY_OV(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .x(x), .y(y), .shamt(shamt), .flag_clr(flag_clr),
    .out_valid(out_valid), .result(result), .hi(hi), .lo(lo), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following the accept edge.
  task automatic send(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] s);
    in_valid = 1'b1; op = o; x = a; y = b; shamt = s;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts busy cycles after a mul/div accept; pokes a stray op mid-flight.
  task automatic wait_md(output int nbusy, output int npulse);
    nbusy = 0; npulse = 0;
    for (int g = 0; g < 100 && !in_ready; g++) begin
      nbusy++;
      if (out_valid) npulse++;
      if (nbusy == 5) begin
        in_valid = 1'b1; op = 4'h0; x = 32'd1; y = 32'd1;
      end
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flag_clr = 1'b0;
    op = '0; x = '0; y = '0; shamt = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", 64'(in_ready), 64'h1);
    chk("rst_oval",  64'(out_valid), 64'h0);
    chk("rst_res",   64'(result), 64'h0);
    chk("rst_hilo",  {hi, lo}, 64'h0);
    chk("rst_flags", 64'(flags), 64'h0);

    // ADD overflow, latency one cycle after accept
    send(4'h0, 32'h7FFF_FFFF, 32'h1, 5'd0);
    chk("add_lat0", 64'(out_valid), 64'h0);
    @(negedge clk);
    chk("add_oval",  64'(out_valid), 64'h1);
    chk("add_res",   64'(result), 64'h8000_0000);
    chk("add_flags", 64'(flags), 64'h6);
    chk("add_ready", 64'(in_ready), 64'h1);

    send(4'h1, 32'd5, 32'd5, 5'd0);
    @(negedge clk);
    chk("sub_res",   64'(result), 64'h0);
    chk("sub_flags", 64'(flags), 64'h3);

    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    chk("clr_flags", 64'(flags), 64'h1);
    chk("clr_oval",  64'(out_valid), 64'h0);

    // Back-to-back SLT, SLTU, SRA
    in_valid = 1'b1; op = 4'h6; x = 32'hFFFF_FFFF; y = 32'h1; shamt = '0;
    @(negedge clk);
    op = 4'h7;
    @(negedge clk);
    chk("slt_oval", 64'(out_valid), 64'h1);
    chk("slt_res",  64'(result), 64'h1);
    op = 4'hA; x = 32'h8000_0000; shamt = 5'd4;
    @(negedge clk);
    in_valid = 1'b0;
    chk("sltu_oval",  64'(out_valid), 64'h1);
    chk("sltu_res",   64'(result), 64'h0);
    chk("sltu_flags", 64'(flags), 64'h1);
    @(negedge clk);
    chk("sra_oval",  64'(out_valid), 64'h1);
    chk("sra_res",   64'(result), 64'hF800_0000);
    chk("sra_flags", 64'(flags), 64'h4);
    chk("sra_hilo",  {hi, lo}, 64'h0);
    @(negedge clk);
    chk("b2b_end",   64'(out_valid), 64'h0);

    // MULT -3 * 7
    send(4'hC, 32'hFFFF_FFFD, 32'd7, 5'd0);
    wait_md(busy, pulses);
    chk("mult_busy",   64'(busy), 64'd33);
    chk("mult_pulse0", 64'(pulses), 64'd0);
    chk("mult_oval",   64'(out_valid), 64'h1);
    chk("mult_hilo",   {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("mult_res",    64'(result), 64'hFFFF_FFEB);
    chk("mult_flags",  64'(flags), 64'h4);
    @(negedge clk);
    chk("mult_single", 64'(out_valid), 64'h0);

    send(4'hD, 32'hFFFF_FFFF, 32'd2, 5'd0);
    wait_md(busy, pulses);
    chk("multu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

    send(4'hE, 32'hFFFF_FFF9, 32'd2, 5'd0);
    wait_md(busy, pulses);
    chk("div_hilo",  {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("div_flags", 64'(flags), 64'h4);

    send(4'hF, 32'd100, 32'd7, 5'd0);
    wait_md(busy, pulses);
    chk("divu_busy",  64'(busy), 64'd33);
    chk("divu_hilo",  {hi, lo}, {32'd2, 32'd14});
    chk("divu_flags", 64'(flags), 64'h0);

    send(4'hE, 32'd9, 32'd0, 5'd0);
    wait_md(busy, pulses);
    chk("dvz_hilo",  {hi, lo}, {32'd9, 32'hFFFF_FFFF});
    chk("dvz_flags", 64'(flags), 64'hC);

    // flag_clr coincident with an overflowing ADD: OVF set wins, DVZ cleared, HI/LO kept
    send(4'h0, 32'h7FFF_FFFF, 32'h1, 5'd0);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    chk("coin_flags", 64'(flags), 64'h6);
    chk("coin_hilo",  {hi, lo}, {32'd9, 32'hFFFF_FFFF});

    send(4'hE, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
    wait_md(busy, pulses);
    chk("dovf_hilo",  {hi, lo}, {32'h0, 32'h8000_0000});
    chk("dovf_flags", 64'(flags), 64'h6);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    chk("dovf_clr", 64'(flags), 64'h4);

    // Reset mid-DIVU aborts the operation
    send(4'hF, 32'd100, 32'd7, 5'd0);
    repeat (10) @(negedge clk);
    chk("abort_busy", 64'(in_ready), 64'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", 64'(in_ready), 64'h1);
    chk("abort_hilo",  {hi, lo}, 64'h0);
    chk("abort_flags", 64'(flags), 64'h0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) pulses++;
      @(negedge clk);
    end
    chk("abort_nopulse", 64'(pulses), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
